// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - Wishbone-classic instruction bus between fetch and instruction RAM
//
// Signals (direction given from the fetch side):
//   iaddr_o  out 32  byte address of the current request
//   idat_i   in  32  read data, valid while iack_i=1
//   isel_o   out 1   select, mirrors istb_o
//   icyc_o   out 1   bus cycle active
//   istb_o   out 1   strobe, mirrors icyc_o
//   iwe_o    out 1   write enable, always 0
//   iack_i   in  1   slave acknowledge
//   ierr_i   in  1   slave error
// Modports: master (fetch stage), slave (instruction RAM).

interface ifetch_if;
  logic [31:0] iaddr_o;
  logic [31:0] idat_i;
  logic        isel_o;
  logic        icyc_o;
  logic        istb_o;
  logic        iwe_o;
  logic        iack_i;
  logic        ierr_i;

  modport master (
    output iaddr_o, isel_o, icyc_o, istb_o, iwe_o,
    input  idat_i, iack_i, ierr_i
  );

  modport slave (
    input  iaddr_o, isel_o, icyc_o, istb_o, iwe_o,
    output idat_i, iack_i, ierr_i
  );
endinterface

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage with single-entry output register
//
// Ports:
//   clk            in  1   clock, rising edge
//   rst            in  1   synchronous active-high reset
//   bus            ifetch_if.master  instruction bus (Wishbone classic, read only)
//   redirect_i     in  1   one-cycle pulse, restart fetch at redirect_pc_i
//   redirect_pc_i  in  32  new PC
//   stall_i        in  1   decode cannot accept, output register holds
//   instr_o        out 32  fetched instruction (0 for a fault entry)
//   pc_o           out 32  address of instr_o
//   valid_o        out 1   instr_o/pc_o/fault_o meaningful
//   fault_o        out 1   entry is a bus error or misaligned-PC exception
// Parameter:
//   RESET_ADDR     PC after reset, first fetch address.

module ifetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  ifetch_if.master    bus,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic        kill_q, kill_d;
  // Address of a request that was killed by a redirect; keeps iaddr_o
  // stable until the stale response arrives even though the PC has moved.
  logic [31:0] kill_addr_q;

  logic resp;
  logic slot_free;
  logic misaligned;
  logic load_ack;
  logic load_err;
  logic req;

  assign resp       = bus.iack_i || bus.ierr_i;
  assign slot_free  = !valid_o || !stall_i;
  assign misaligned = (redirect_pc_i[1:0] != 2'b00);

  // Strobe is masked by the response itself so a registered-ack slave
  // sees it low in the ack cycle and cannot acknowledge twice.
  assign req         = (state_q == S_BUSY) && !resp;
  assign bus.icyc_o  = req;
  assign bus.istb_o  = req;
  assign bus.isel_o  = req;
  assign bus.iwe_o   = 1'b0;
  assign bus.iaddr_o = kill_q ? kill_addr_q : pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    load_ack = 1'b0;
    load_err = 1'b0;
    if (redirect_i) begin
      kill_d = 1'b0;
      if (misaligned) begin
        state_d = S_FAULT;
      end else if ((state_q == S_BUSY) && !resp) begin
        // Request stays on the bus until its response, which is then dropped.
        state_d = S_BUSY;
        kill_d  = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (slot_free) state_d = S_BUSY;
        end
        S_BUSY: begin
          if (resp) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_IDLE;
            end else if (bus.ierr_i) begin
              load_err = 1'b1;
              state_d  = S_FAULT;
            end else begin
              load_ack = 1'b1;
              state_d  = S_IDLE;
            end
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_ADDR;
      kill_addr_q <= RESET_ADDR;
      instr_o     <= 32'h0;
      pc_o        <= 32'h0;
      valid_o     <= 1'b0;
      fault_o     <= 1'b0;
    end else begin
      if (redirect_i && !kill_q) kill_addr_q <= pc_q;
      if (redirect_i) begin
        pc_q <= redirect_pc_i;
        if (misaligned) begin
          instr_o <= 32'h0;
          pc_o    <= redirect_pc_i;
          valid_o <= 1'b1;
          fault_o <= 1'b1;
        end else begin
          valid_o <= 1'b0;
          fault_o <= 1'b0;
        end
      end else if (load_ack) begin
        instr_o <= bus.idat_i;
        pc_o    <= pc_q;
        valid_o <= 1'b1;
        fault_o <= 1'b0;
        pc_q    <= pc_q + 32'd4;
      end else if (load_err) begin
        instr_o <= 32'h0;
        pc_o    <= pc_q;
        valid_o <= 1'b1;
        fault_o <= 1'b1;
      end else if (valid_o && !stall_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
